inst_rom_loader: RTL

- Responder end of the CPU instruction-fetch interface: asynchronous-read instruction ROM answering the core's chip-enable/address fetch port.
- Adds a byte-stream load port that fills the ROM after reset while the core is held in reset.
- Sits beside the processor top level in the SoC wrapper; the loader feeds it from a host link or testbench.

---
 rtl/inst_rom_loader_pkg.sv | 15 +
 rtl/inst_rom_mem.sv | 25 ++
 rtl/inst_rom_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, constants and state encoding for the instruction ROM loader.
package inst_rom_loader_pkg;

  localparam int InstBus          = 32;
  localparam int InstAddrBus      = 32;
  localparam int DefaultDepthLog2 = 10;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction ROM storage: one synchronous write port, one asynchronous read port.
module inst_rom_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [InstBus-1:0]    wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [InstBus-1:0]    rdata
);

  logic [InstBus-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a big-endian byte-stream load port; holds the core in reset
// until the image is loaded, then serves zero-latency fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_data_o,
  input  logic                   ld_valid_i,
  input  logic [7:0]             ld_data_i,
  input  logic                   ld_last_i,
  output logic                   ld_ready_o,
  output logic                   cpu_rst_o,
  output logic                   load_done_o,
  output logic                   load_err_o,
  output logic [DEPTH_LOG2:0]    word_count_o
);

  state_t                state;
  logic [1:0]            byte_cnt;
  logic [InstBus-1:0]    shift;
  logic [InstBus-1:0]    merged;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  xfer;
  logic                  full;
  logic                  word_end;
  logic                  do_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic [InstBus-1:0]    rd_word;
  logic                  hi_zero;
  logic                  in_image;
  logic                  unused_addr_lsb;

  assign ld_ready_o = (state == S_LOAD);
  assign xfer       = ld_valid_i & ld_ready_o;
  // The counter can never pass the depth, so its MSB alone means "ROM full".
  assign full       = word_count_o[DEPTH_LOG2];
  assign word_end   = (byte_cnt == 2'd3) | ld_last_i;
  assign do_write   = xfer & word_end & ~full;

  // Unfilled low bytes of shift are zero, which pads a short final word.
  always_comb begin
    merged = shift;
    case (byte_cnt)
      2'd0:    merged[31:24] = ld_data_i;
      2'd1:    merged[23:16] = ld_data_i;
      2'd2:    merged[15:8]  = ld_data_i;
      default: merged[7:0]   = ld_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      byte_cnt     <= 2'd0;
      shift        <= '0;
      wr_ptr       <= '0;
      word_count_o <= '0;
      load_err_o   <= 1'b0;
      load_done_o  <= 1'b0;
      cpu_rst_o    <= 1'b1;
    end else if (xfer) begin
      byte_cnt <= ld_last_i ? 2'd0 : byte_cnt + 2'd1;
      shift    <= word_end ? '0 : merged;
      if (full) begin
        load_err_o <= 1'b1;
      end
      if (do_write) begin
        wr_ptr       <= wr_ptr + 1'b1;
        word_count_o <= word_count_o + 1'b1;
      end
      if (ld_last_i) begin
        state       <= S_RUN;
        cpu_rst_o   <= 1'b0;
        load_done_o <= 1'b1;
      end
    end
  end

  inst_rom_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (do_write),
    .waddr(wr_ptr),
    .wdata(merged),
    .raddr(idx),
    .rdata(rd_word)
  );

  // Byte offset within the word is irrelevant to a word-aligned fetch.
  assign unused_addr_lsb = ^rom_addr_i[1:0];
  assign idx      = rom_addr_i[DEPTH_LOG2+1:2];
  assign hi_zero  = (rom_addr_i[InstAddrBus-1:DEPTH_LOG2+2] == '0);
  assign in_image = ({1'b0, idx} < word_count_o);

  // Masking by word count hides stale contents left over from before a reset.
  assign rom_data_o = (rom_ce_i && (state == S_RUN) && hi_zero && in_image) ? rd_word : ZeroWord;

endmodule
